keyexpansion_store: RTL and testbench

- Runtime-selectable AES key schedule (128/192/256-bit keys) that expands one 32-bit word per cycle into an internal round-key store.
- Once expansion completes, it serves any round key by index, in forward (encrypt) or reverse (decrypt) order, with 1-cycle read latency.
- Sits between the key-load interface and the cipher/inverse-cipher datapaths. It replaces the fixed-K, lockstep round-key feed with a reusable, randomly addressable schedule.

---
 rtl/aes_key_pkg.sv | 93 +++++++++
 rtl/keyword_next.sv | 41 ++++
 rtl/subword.sv | 16 +
 rtl/keyexpansion_store.sv | 224 ++++++++++++++++++++++
 tb/tb_keyexpansion_store.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_pkg.sv
// aes_key_pkg
// Shared types and helpers for the AES key-schedule store.
//   keysize_t : encoding of the keySize input (128/192/256/reserved)
//   state_t   : expansion controller states
//   nw_of()   : depth of the round-key store for a given maximum key length
//   nk_of()   : key length in 32-bit words (0 for the reserved encoding)
//   nr_of()   : number of cipher rounds (0 for the reserved encoding)
//   xtime()   : multiply by x in GF(2^8), reduced with 0x1b
//   sbox()    : AES S-box, computed as GF(2^8) inverse plus affine map
package aes_key_pkg;

    typedef enum logic [1:0] {
        KS128 = 2'b00,
        KS192 = 2'b01,
        KS256 = 2'b10,
        KSRSV = 2'b11
    } keysize_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } state_t;

    // The sliding window always holds the eight most recent words, which
    // covers w[i-Nk] for the longest key.
    localparam int WIN_WORDS = 8;

    // Word index width; 6 bits address up to 64 words, enough for 60.
    localparam int IDX_W = 6;

    function automatic int nw_of(input int maxk);
        return 4 * (maxk / 32 + 7);
    endfunction

    function automatic logic [3:0] nk_of(input keysize_t ks);
        case (ks)
            KS128:   return 4'd4;
            KS192:   return 4'd6;
            KS256:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input keysize_t ks);
        if (ks == KSRSV) begin
            return 4'd0;
        end
        return nk_of(ks) + 4'd6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h01;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) begin
                r = gf_mul(r, t);
            end
            t = gf_mul(t, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/keyword_next.sv
// keyword_next
// Combinational step of the key schedule: produces w[i] from w[i-1]
// and w[i-Nk].
//   wPrev : w[i-1]
//   wBack : w[i-Nk]
//   rcon  : current round constant (top byte of the Rcon word)
//   doRot : i mod Nk == 0 -> SubWord(RotWord(wPrev)) ^ {rcon,24'h0}
//   doSub : 256-bit key and i mod 8 == 4 -> SubWord(wPrev)
//   wNext : w[i]
module keyword_next (
    input  logic [31:0] wPrev,
    input  logic [31:0] wBack,
    input  logic [7:0]  rcon,
    input  logic        doRot,
    input  logic        doSub,
    output logic [31:0] wNext
);

    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;

    // One S-box bank serves both cases; rotation happens before it.
    assign sub_in = doRot ? {wPrev[23:0], wPrev[31:24]} : wPrev;

    subword u_subword (
        .wIn  (sub_in),
        .wOut (sub_out)
    );

    always_comb begin
        temp = wPrev;
        if (doRot) begin
            temp = sub_out ^ {rcon, 24'h000000};
        end else if (doSub) begin
            temp = sub_out;
        end
        wNext = wBack ^ temp;
    end

endmodule

// File: rtl/subword.sv
// subword
// Applies the AES S-box to each byte of a 32-bit word.
//   wIn  : input word
//   wOut : byte-wise substituted word
module subword
    import aes_key_pkg::*;
(
    input  logic [31:0] wIn,
    output logic [31:0] wOut
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign wOut[8*b +: 8] = sbox(wIn[8*b +: 8]);
    end

endmodule

// File: rtl/keyexpansion_store.sv
// keyexpansion_store
// Runtime-selectable AES key schedule (128/192/256) that expands one word
// per cycle into an internal store, then serves round keys by index in
// forward or reverse order with one cycle of read latency.
//   clk, reset      : clock, asynchronous active-low reset
//   start, keySize  : request a new expansion (honoured in IDLE/DONE only)
//   key             : key, MSB-aligned within MAXK bits
//   busy, ready     : expansion running / complete schedule held
//   err             : last start request was rejected
//   numRounds       : Nr of the stored schedule, 0 when not ready
//   rdEn/rdRev/rdIdx: round-key read request
//   rdKey, rdValid  : registered read data and its one-cycle strobe
module keyexpansion_store
    import aes_key_pkg::*;
#(
    parameter int MAXK = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      keySize,
    input  logic [MAXK-1:0] key,
    output logic            busy,
    output logic            ready,
    output logic            err,
    output logic [3:0]      numRounds,
    input  logic            rdEn,
    input  logic            rdRev,
    input  logic [3:0]      rdIdx,
    output logic [127:0]    rdKey,
    output logic            rdValid
);

    localparam int NW     = nw_of(MAXK);
    localparam int NK_MAX = MAXK / 32;

    state_t          state_q, state_d;
    keysize_t        ks_q, ks_d;
    logic [MAXK-1:0] key_q, key_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [2:0]      rem_q, rem_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [31:0]     win_q [WIN_WORDS];
    logic [31:0]     win_d [WIN_WORDS];
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [3:0]      nr_q, nr_d;
    logic [127:0]    rd_key_q, rd_key_d;
    logic            rd_valid_q, rd_valid_d;

    logic [31:0]     store_q [NW];

    logic [31:0]     kw [WIN_WORDS];
    logic [3:0]      nk;
    logic [3:0]      start_nk;
    logic            start_ok;
    logic [IDX_W-1:0] last_idx;
    logic            do_rot;
    logic            do_sub;
    logic [31:0]     w_back;
    logic [31:0]     w_next;
    logic [3:0]      rd_j;
    logic [IDX_W-1:0] rd_base;

    // Split the captured key into words; w[0] is the most significant word.
    for (genvar m = 0; m < WIN_WORDS; m++) begin : g_kw
        if (m < NK_MAX) begin : g_used
            assign kw[m] = key_q[MAXK-1-32*m -: 32];
        end else begin : g_unused
            assign kw[m] = 32'h0;
        end
    end

    assign nk       = nk_of(ks_q);
    assign start_nk = nk_of(keysize_t'(keySize));
    assign start_ok = (keysize_t'(keySize) != KSRSV) && (int'(start_nk) * 32 <= MAXK);

    // Last word index is 4*(Nr+1)-1 = 4*Nr+3.
    assign last_idx = {nr_of(ks_q), 2'b11};

    // rem_q tracks i mod Nk so the 192-bit case needs no divider.
    assign do_rot = (rem_q == 3'd0);
    assign do_sub = (ks_q == KS256) && (rem_q == 3'd4);

    // win_q[0] is w[i-1], so w[i-Nk] sits at win_q[Nk-1].
    assign w_back = win_q[3'(nk - 4'd1)];

    keyword_next u_keyword_next (
        .wPrev (win_q[0]),
        .wBack (w_back),
        .rcon  (rcon_q),
        .doRot (do_rot),
        .doSub (do_sub),
        .wNext (w_next)
    );

    // Controller: start handling, key load and one-word-per-cycle expansion.
    always_comb begin
        state_d = state_q;
        ks_d    = ks_q;
        key_d   = key_q;
        i_d     = i_q;
        rem_d   = rem_q;
        rcon_d  = rcon_q;
        win_d   = win_q;
        ready_d = ready_q;
        err_d   = err_q;
        nr_d    = nr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ready_d = 1'b0;
                    nr_d    = 4'd0;
                    if (start_ok) begin
                        ks_d    = keysize_t'(keySize);
                        key_d   = key;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOAD: begin
                for (int k = 0; k < WIN_WORDS; k++) begin
                    if (k < int'(nk)) begin
                        win_d[k] = kw[3'(nk - 4'd1 - 4'(k))];
                    end
                end
                i_d     = IDX_W'(nk);
                rem_d   = 3'd0;
                rcon_d  = 8'h01;
                state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                win_d[0] = w_next;
                for (int k = 1; k < WIN_WORDS; k++) begin
                    win_d[k] = win_q[k-1];
                end
                i_d   = i_q + 1'b1;
                rem_d = (rem_q == 3'(nk - 4'd1)) ? 3'd0 : rem_q + 3'd1;
                if (do_rot) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == last_idx) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    nr_d    = nr_of(ks_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read port: served only from a complete schedule, otherwise rdKey holds.
    always_comb begin
        rd_key_d   = rd_key_q;
        rd_valid_d = 1'b0;
        rd_j       = rdRev ? (nr_q - rdIdx) : rdIdx;
        rd_base    = {rd_j, 2'b00};
        if (rdEn && (state_q == ST_DONE) && (rdIdx <= nr_q)) begin
            rd_key_d   = {store_q[rd_base], store_q[rd_base + 6'd1],
                          store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ks_q       <= KS128;
            key_q      <= '0;
            i_q        <= '0;
            rem_q      <= '0;
            rcon_q     <= 8'h01;
            for (int k = 0; k < WIN_WORDS; k++) begin
                win_q[k] <= 32'h0;
            end
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            nr_q       <= 4'd0;
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ks_q       <= ks_d;
            key_q      <= key_d;
            i_q        <= i_d;
            rem_q      <= rem_d;
            rcon_q     <= rcon_d;
            win_q      <= win_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            nr_q       <= nr_d;
            rd_key_q   <= rd_key_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Store has no reset; ready_q guards against reading stale contents.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            for (int m = 0; m < WIN_WORDS; m++) begin
                if (m < int'(nk)) begin
                    store_q[m] <= kw[m];
                end
            end
        end else if (state_q == ST_EXPAND) begin
            store_q[i_q] <= w_next;
        end
    end

    assign busy      = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
    assign ready     = ready_q;
    assign err       = err_q;
    assign numRounds = nr_q;
    assign rdKey     = rd_key_q;
    assign rdValid   = rd_valid_q;

endmodule

// File: tb/tb_keyexpansion_store.sv
// tb_keyexpansion_store
// Directed and randomized checks of keyexpansion_store (MAXK=256) against
// a reference key schedule built from S-box/Rcon tables in the bench.
module tb_keyexpansion_store;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   keySize;
    logic [255:0] key;
    logic         busy;
    logic         ready;
    logic         err;
    logic [3:0]   numRounds;
    logic         rdEn;
    logic         rdRev;
    logic [3:0]   rdIdx;
    logic [127:0] rdKey;
    logic         rdValid;

    int           nComp;
    int           nFail;

    logic [7:0]   sboxTab [256];
    logic [7:0]   rconTab [10];
    logic [31:0]  mw [60];
    int           mNr;
    logic         mReady;
    logic [127:0] lastKey;

    keyexpansion_store #(.MAXK(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .keySize   (keySize),
        .key       (key),
        .busy      (busy),
        .ready     (ready),
        .err       (err),
        .numRounds (numRounds),
        .rdEn      (rdEn),
        .rdRev     (rdRev),
        .rdIdx     (rdIdx),
        .rdKey     (rdKey),
        .rdValid   (rdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    task automatic buildTables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c63;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8]
                     ^ inv[(b+7)%8] ^ c63[b];
            end
            sboxTab[x] = s;
        end
        rconTab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    task automatic modelExpand(input int nk, input logic [255:0] k);
        logic [31:0] temp;
        mNr = nk + 6;
        for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (mNr + 1); i++) begin
            temp = mw[i-1];
            if (i % nk == 0)
                temp = subw({temp[23:0], temp[31:24]}) ^ {rconTab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                temp = subw(temp);
            mw[i] = mw[i-nk] ^ temp;
        end
    endtask

    function automatic logic [127:0] roundKey(input int j);
        return {mw[4*j], mw[4*j+1], mw[4*j+2], mw[4*j+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, then release pulses.
    task automatic applyStimulus(input logic st, input logic [1:0] ks, input logic [255:0] k,
                                 input logic re, input logic rv, input logic [3:0] ri);
        start   = st;
        keySize = ks;
        key     = k;
        rdEn    = re;
        rdRev   = rv;
        rdIdx   = ri;
        tick();
        start = 1'b0;
        rdEn  = 1'b0;
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic startRun(input logic [1:0] ks, input logic [255:0] k, input string tag);
        int nk;
        int n;
        nk = 4 + 2 * int'(ks);
        mReady = 1'b0;
        modelExpand(nk, k);
        applyStimulus(1'b1, ks, k, 1'b0, 1'b0, 4'd0);
        checkOutput({tag, "_busy"}, 128'(busy), 128'(1));
        checkOutput({tag, "_readyLow"}, 128'(ready), 128'(0));
        waitReady(n);
        checkOutput({tag, "_latency"}, 128'(n), 128'(1 + 4 * (nk + 7) - nk));
        checkOutput({tag, "_numRounds"}, 128'(numRounds), 128'(mNr));
        mReady = 1'b1;
    endtask

    task automatic readAndCheck(input logic rev, input logic [3:0] idx, input string tag);
        logic expV;
        int   j;
        expV = 1'b0;
        if (mReady && int'(idx) <= mNr) begin
            j = rev ? mNr - int'(idx) : int'(idx);
            lastKey = roundKey(j);
            expV = 1'b1;
        end
        applyStimulus(1'b0, 2'b00, '0, 1'b1, rev, idx);
        checkOutput({tag, "_rdValid"}, 128'(rdValid), 128'(expV));
        checkOutput({tag, "_rdKey"}, rdKey, lastKey);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic [255:0] rk;
        logic [127:0] expOld;
        logic [1:0]   rks;

        nComp   = 0;
        nFail   = 0;
        mReady  = 1'b0;
        lastKey = '0;
        reset   = 1'b0;
        start   = 1'b0;
        keySize = 2'b00;
        key     = '0;
        rdEn    = 1'b0;
        rdRev   = 1'b0;
        rdIdx   = 4'd0;
        buildTables();

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_ready", 128'(ready), 128'(0));
        checkOutput("rst_err", 128'(err), 128'(0));
        checkOutput("rst_numRounds", 128'(numRounds), 128'(0));
        checkOutput("rst_rdKey", rdKey, 128'(0));
        checkOutput("rst_rdValid", 128'(rdValid), 128'(0));
        reset = 1'b1;
        tick();

        // Read before any schedule exists is not served
        readAndCheck(1'b0, 4'd0, "idle_read");

        // FIPS-197 128-bit key
        startRun(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, "k128");
        readAndCheck(1'b0, 4'd10, "k128_r10");
        checkOutput("k128_fips", rdKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        checkOutput("k128_pulse", 128'(rdValid), 128'(0));
        readAndCheck(1'b1, 4'd10, "k128_rev10");

        // FIPS-197 192-bit key
        startRun(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, "k192");
        readAndCheck(1'b1, 4'd0, "k192_rev0");
        checkOutput("k192_fips", rdKey, 128'he98ba06f448c773c8ecc720401002202);

        // FIPS-197 256-bit key
        startRun(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, "k256");
        readAndCheck(1'b0, 4'd14, "k256_r14");
        checkOutput("k256_fips", rdKey, 128'hfe4890d1e6188d0b046df344706c631e);
        readAndCheck(1'b0, 4'd15, "k256_r15");
        readAndCheck(1'b1, 4'd15, "k256_rev15");

        // Reserved key size is rejected
        mReady = 1'b0;
        applyStimulus(1'b1, 2'b11, '1, 1'b0, 1'b0, 4'd0);
        checkOutput("ill_err", 128'(err), 128'(1));
        checkOutput("ill_ready", 128'(ready), 128'(0));
        checkOutput("ill_busy", 128'(busy), 128'(0));
        checkOutput("ill_numRounds", 128'(numRounds), 128'(0));
        tick();
        checkOutput("ill_errHold", 128'(err), 128'(1));
        readAndCheck(1'b0, 4'd2, "ill_read");
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        startRun(2'b00, rk, "after_ill");
        checkOutput("after_ill_err", 128'(err), 128'(0));
        readAndCheck(1'b0, 4'd5, "after_ill_r5");

        // Second start during expansion is ignored
        modelExpand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        mReady = 1'b0;
        applyStimulus(1'b1, 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 1'b0, 4'd0);
        repeat (19) tick();
        applyStimulus(1'b1, 2'b10, '1, 1'b0, 1'b0, 4'd0);
        checkOutput("ign_busy", 128'(busy), 128'(1));
        waitReady(n);
        checkOutput("ign_latency", 128'(n + 20), 128'(41));
        checkOutput("ign_numRounds", 128'(numRounds), 128'(10));
        mReady = 1'b1;
        readAndCheck(1'b0, 4'd10, "ign_r10");

        // Reset in the middle of an expansion
        mReady = 1'b0;
        applyStimulus(1'b1, 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 1'b0, 4'd0);
        repeat (19) tick();
        applyStimulus(1'b1, 2'b01, '0, 1'b0, 1'b0, 4'd0);
        repeat (9) tick();
        reset = 1'b0;
        #1;
        lastKey = '0;
        checkOutput("mid_rst_ready", 128'(ready), 128'(0));
        checkOutput("mid_rst_busy", 128'(busy), 128'(0));
        checkOutput("mid_rst_numRounds", 128'(numRounds), 128'(0));
        checkOutput("mid_rst_rdKey", rdKey, 128'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("post_rst_ready", 128'(ready), 128'(0));
        readAndCheck(1'b0, 4'd1, "post_rst_read");
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        startRun(2'b10, rk, "post_rst");
        readAndCheck(1'b0, 4'd0, "post_rst_r0");
        readAndCheck(1'b1, 4'd3, "post_rst_rev3");

        // Read and start together in DONE: read comes from the old schedule
        expOld = roundKey(7);
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mReady = 1'b0;
        modelExpand(6, rk);
        applyStimulus(1'b1, 2'b01, rk, 1'b1, 1'b0, 4'd7);
        lastKey = expOld;
        checkOutput("rs_rdValid", 128'(rdValid), 128'(1));
        checkOutput("rs_rdKey", rdKey, expOld);
        checkOutput("rs_ready", 128'(ready), 128'(0));
        checkOutput("rs_busy", 128'(busy), 128'(1));
        waitReady(n);
        checkOutput("rs_latency", 128'(n), 128'(47));
        mReady = 1'b1;
        readAndCheck(1'b0, 4'd12, "rs_r12");
        readAndCheck(1'b1, 4'd12, "rs_rev12");

        // Randomized schedules and reads
        for (int r = 0; r < 6; r++) begin
            rks = 2'($urandom_range(0, 2));
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            startRun(rks, rk, $sformatf("rnd%0d", r));
            for (int q = 0; q < 6; q++) begin
                readAndCheck(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                             $sformatf("rnd%0d_q%0d", r, q));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
